// File: rtl/pll_lock_sequencer_if.sv
// rtl/pll_lock_sequencer_if.sv - PLL lock sequencer signal bundle (lock in, resets/status out)
interface pll_lock_sequencer_if #(
   parameter int RETRY_W = 2
);
   logic               pll_extlock;
   logic               relock_req;
   logic               pll_reset;
   logic               sys_rst;
   logic               ready;
   logic               fault;
   logic               lock_lost;
   logic [RETRY_W-1:0] retry_cnt;

   // PLL wrapper / board side: supplies lock and relock, observes resets and status
   modport master (
      output pll_extlock,
      output relock_req,
      input  pll_reset,
      input  sys_rst,
      input  ready,
      input  fault,
      input  lock_lost,
      input  retry_cnt
   );

   // Sequencer side
   modport slave (
      input  pll_extlock,
      input  relock_req,
      output pll_reset,
      output sys_rst,
      output ready,
      output fault,
      output lock_lost,
      output retry_cnt
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset pulse, lock qualification and system reset release
module pll_lock_sequencer #(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES         = 3
) (
   input  logic                refclk,
   input  logic                reset,
   pll_lock_sequencer_if.slave bus
);
   // One counter serves every timed state, so it is sized for the longest window.
   localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT_CYCLES) ? CNT_MAX_A : LOCK_TIMEOUT_CYCLES;
   localparam int CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam int RETRY_W   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

   localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   typedef struct packed {
      logic pll_reset;
      logic sys_rst;
      logic ready;
      logic fault;
   } outs_t;

   // Output pattern for a state; applied with the state it belongs to so outputs
   // move on the same edge as the state register.
   function automatic outs_t decode(input state_t s);
      outs_t o;
      o.pll_reset = (s == S_PLL_RST) || (s == S_FAULT);
      o.sys_rst   = (s != S_RUN);
      o.ready     = (s == S_RUN);
      o.fault     = (s == S_FAULT);
      return o;
   endfunction

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [RETRY_W-1:0] retry_q;
   logic               lock_lost_q;
   outs_t              outs;
   logic               sync1;
   logic               lock_s;

   // Two-flop synchronizer bringing the asynchronous extlock into refclk
   always_ff @(posedge refclk) begin
      if (reset) begin
         sync1  <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         sync1  <= bus.pll_extlock;
         lock_s <= sync1;
      end
   end

   // Sequencer FSM: state, shared window counter, retry count and registered outputs
   always_ff @(posedge refclk) begin
      if (reset) begin
         state       <= S_PLL_RST;
         cnt         <= '0;
         retry_q     <= '0;
         lock_lost_q <= 1'b0;
         outs        <= decode(S_PLL_RST);
      end else begin
         case (state)
            S_PLL_RST: begin
               if (cnt == PLL_RST_LAST) begin
                  state <= S_WAIT_LOCK;
                  cnt   <= '0;
                  outs  <= decode(S_WAIT_LOCK);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_WAIT_LOCK: begin
               // A lock seen on the final timeout cycle still counts as a lock.
               if (lock_s) begin
                  state <= S_STABLE;
                  cnt   <= '0;
                  outs  <= decode(S_STABLE);
               end else if (cnt == TIMEOUT_LAST) begin
                  cnt <= '0;
                  if (retry_q == RETRY_LAST) begin
                     state <= S_FAULT;
                     outs  <= decode(S_FAULT);
                  end else begin
                     state   <= S_PLL_RST;
                     retry_q <= retry_q + 1'b1;
                     outs    <= decode(S_PLL_RST);
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_STABLE: begin
               // A dropout here is treated as a glitch: restart the timeout window
               // without spending a retry.
               if (!lock_s) begin
                  state <= S_WAIT_LOCK;
                  cnt   <= '0;
                  outs  <= decode(S_WAIT_LOCK);
               end else if (cnt == STABLE_LAST) begin
                  state <= S_RUN;
                  cnt   <= '0;
                  outs  <= decode(S_RUN);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_RUN: begin
               // Lock loss outranks a simultaneous relock request so it is recorded.
               if (!lock_s) begin
                  state       <= S_PLL_RST;
                  cnt         <= '0;
                  retry_q     <= '0;
                  lock_lost_q <= 1'b1;
                  outs        <= decode(S_PLL_RST);
               end else if (bus.relock_req) begin
                  state   <= S_PLL_RST;
                  cnt     <= '0;
                  retry_q <= '0;
                  outs    <= decode(S_PLL_RST);
               end
            end

            S_FAULT: begin
               // Only an explicit relock leaves the fault; lock status is ignored.
               if (bus.relock_req) begin
                  state   <= S_PLL_RST;
                  cnt     <= '0;
                  retry_q <= '0;
                  outs    <= decode(S_PLL_RST);
               end
            end

            default: begin
               state <= S_PLL_RST;
               cnt   <= '0;
               outs  <= decode(S_PLL_RST);
            end
         endcase
      end
   end

   assign bus.pll_reset = outs.pll_reset;
   assign bus.sys_rst   = outs.sys_rst;
   assign bus.ready     = outs.ready;
   assign bus.fault     = outs.fault;
   assign bus.lock_lost = lock_lost_q;
   assign bus.retry_cnt = retry_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed bench for pll_lock_sequencer with phase/countdown model
module tb_pll_lock_sequencer;
   localparam int PRC = 4;
   localparam int LSC = 8;
   localparam int LTC = 32;
   localparam int MR  = 2;
   localparam int RW  = 2;

   localparam int P_RST   = 0;
   localparam int P_WAIT  = 1;
   localparam int P_STAB  = 2;
   localparam int P_RUN   = 3;
   localparam int P_FAULT = 4;

   logic refclk = 1'b0;
   logic reset;

   pll_lock_sequencer_if #(.RETRY_W(RW)) bus ();

   pll_lock_sequencer #(
      .PLL_RST_CYCLES      (PRC),
      .LOCK_STABLE_CYCLES  (LSC),
      .LOCK_TIMEOUT_CYCLES (LTC),
      .MAX_RETRIES         (MR)
   ) dut (
      .refclk (refclk),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 refclk = ~refclk;

   int n_checks = 0;
   int n_pass   = 0;
   int cycle    = 0;

   // model: phase, cycles left in the current window, retries, sticky loss, lock delay line
   int   m_phase   = P_RST;
   int   m_left    = PRC;
   int   m_retries = 0;
   int   m_lost    = 0;
   logic m_s0      = 1'b0;
   logic m_s1      = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cycle, act, exp);
   endtask

   task automatic m_enter(input int p);
      m_phase = p;
      case (p)
         P_RST:   m_left = PRC;
         P_WAIT:  m_left = LTC;
         P_STAB:  m_left = LSC;
         default: m_left = 0;
      endcase
   endtask

   task automatic model_step();
      logic lk;
      if (reset) begin
         m_enter(P_RST);
         m_retries = 0;
         m_lost    = 0;
         m_s0      = 1'b0;
         m_s1      = 1'b0;
      end else begin
         lk   = m_s1;
         m_s1 = m_s0;
         m_s0 = bus.pll_extlock;
         case (m_phase)
            P_RST: begin
               m_left--;
               if (m_left == 0) m_enter(P_WAIT);
            end
            P_WAIT: begin
               if (lk) m_enter(P_STAB);
               else begin
                  m_left--;
                  if (m_left == 0) begin
                     if (m_retries == MR) m_enter(P_FAULT);
                     else begin
                        m_retries++;
                        m_enter(P_RST);
                     end
                  end
               end
            end
            P_STAB: begin
               if (!lk) m_enter(P_WAIT);
               else begin
                  m_left--;
                  if (m_left == 0) m_enter(P_RUN);
               end
            end
            P_RUN: begin
               if (!lk) begin
                  m_lost    = 1;
                  m_retries = 0;
                  m_enter(P_RST);
               end else if (bus.relock_req) begin
                  m_retries = 0;
                  m_enter(P_RST);
               end
            end
            default: begin
               if (bus.relock_req) begin
                  m_retries = 0;
                  m_enter(P_RST);
               end
            end
         endcase
      end
   endtask

   task automatic compare_all();
      chk("cyc_pll_reset", 32'(bus.pll_reset), 32'(m_phase == P_RST || m_phase == P_FAULT));
      chk("cyc_sys_rst",   32'(bus.sys_rst),   32'(m_phase != P_RUN));
      chk("cyc_ready",     32'(bus.ready),     32'(m_phase == P_RUN));
      chk("cyc_fault",     32'(bus.fault),     32'(m_phase == P_FAULT));
      chk("cyc_lock_lost", 32'(bus.lock_lost), m_lost);
      chk("cyc_retry_cnt", 32'(bus.retry_cnt), m_retries);
   endtask

   // one step per rising edge: advance model after the edge, compare on the falling edge
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge refclk);
         #1;
         cycle++;
         model_step();
         @(negedge refclk);
         compare_all();
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_pll_reset"}, 32'(bus.pll_reset), 1);
      chk({tag, "_sys_rst"},   32'(bus.sys_rst),   1);
      chk({tag, "_ready"},     32'(bus.ready),     0);
      chk({tag, "_fault"},     32'(bus.fault),     0);
      chk({tag, "_lock_lost"}, 32'(bus.lock_lost), 0);
      chk({tag, "_retry_cnt"}, 32'(bus.retry_cnt), 0);
   endtask

   initial begin
      reset           = 1'b1;
      bus.pll_extlock = 1'b0;
      bus.relock_req  = 1'b0;

      // normal bring-up
      tick(3);
      chk_reset_values("t1_reset");
      reset = 1'b0;
      tick(3);
      chk("t1_pll_reset_held", 32'(bus.pll_reset), 1);
      tick(1);
      chk("t1_pll_reset_released", 32'(bus.pll_reset), 0);
      tick(6);
      bus.pll_extlock = 1'b1;
      tick(10);
      chk("t1_ready_not_early", 32'(bus.ready), 0);
      tick(1);
      chk("t1_ready", 32'(bus.ready), 1);
      chk("t1_sys_rst", 32'(bus.sys_rst), 0);
      chk("t1_retry_cnt", 32'(bus.retry_cnt), 0);

      // relock request in RUN, then ignored in WAIT_LOCK
      tick(2);
      bus.relock_req = 1'b1;
      tick(1);
      bus.relock_req = 1'b0;
      chk("t5_ready", 32'(bus.ready), 0);
      chk("t5_pll_reset", 32'(bus.pll_reset), 1);
      chk("t5_lock_lost", 32'(bus.lock_lost), 0);
      bus.pll_extlock = 1'b0;
      tick(4);
      chk("t5_in_wait", 32'(bus.pll_reset), 0);
      tick(1);
      bus.relock_req = 1'b1;
      tick(1);
      bus.relock_req = 1'b0;
      chk("t5_relock_ignored_in_wait", 32'(bus.pll_reset), 0);
      tick(3);
      bus.pll_extlock = 1'b1;
      tick(20);
      chk("t5_ready_again", 32'(bus.ready), 1);

      // lock loss in RUN
      bus.pll_extlock = 1'b0;
      tick(2);
      chk("t4_ready_before_loss", 32'(bus.ready), 1);
      tick(1);
      chk("t4_ready", 32'(bus.ready), 0);
      chk("t4_sys_rst", 32'(bus.sys_rst), 1);
      chk("t4_lock_lost", 32'(bus.lock_lost), 1);
      chk("t4_pll_reset", 32'(bus.pll_reset), 1);
      bus.pll_extlock = 1'b1;
      tick(3);
      chk("t4_pll_reset_held", 32'(bus.pll_reset), 1);
      tick(1);
      chk("t4_pll_reset_released", 32'(bus.pll_reset), 0);
      tick(8);
      chk("t4_ready_not_early", 32'(bus.ready), 0);
      tick(1);
      chk("t4_ready_restored", 32'(bus.ready), 1);
      chk("t4_lock_lost_sticky", 32'(bus.lock_lost), 1);

      // lock glitch during STABLE
      bus.relock_req  = 1'b1;
      bus.pll_extlock = 1'b0;
      tick(1);
      bus.relock_req = 1'b0;
      chk("t3_restart", 32'(bus.pll_reset), 1);
      tick(8);
      bus.pll_extlock = 1'b1;
      tick(5);
      bus.pll_extlock = 1'b0;
      tick(1);
      bus.pll_extlock = 1'b1;
      tick(2);
      chk("t3_glitch_retry_cnt", 32'(bus.retry_cnt), 0);
      chk("t3_glitch_no_pll_reset", 32'(bus.pll_reset), 0);
      tick(8);
      chk("t3_ready_not_early", 32'(bus.ready), 0);
      tick(1);
      chk("t3_ready", 32'(bus.ready), 1);

      // timeouts to fault
      bus.pll_extlock = 1'b0;
      tick(3);
      chk("t2_first_pulse", 32'(bus.pll_reset), 1);
      chk("t2_retry0", 32'(bus.retry_cnt), 0);
      tick(3);
      chk("t2_first_pulse_end", 32'(bus.pll_reset), 1);
      tick(1);
      chk("t2_wait1", 32'(bus.pll_reset), 0);
      tick(31);
      chk("t2_wait1_end", 32'(bus.pll_reset), 0);
      tick(1);
      chk("t2_second_pulse", 32'(bus.pll_reset), 1);
      chk("t2_retry1", 32'(bus.retry_cnt), 1);
      tick(3);
      chk("t2_second_pulse_end", 32'(bus.pll_reset), 1);
      tick(1);
      chk("t2_wait2", 32'(bus.pll_reset), 0);
      tick(31);
      chk("t2_wait2_end", 32'(bus.pll_reset), 0);
      tick(1);
      chk("t2_third_pulse", 32'(bus.pll_reset), 1);
      chk("t2_retry2", 32'(bus.retry_cnt), 2);
      tick(3);
      chk("t2_third_pulse_end", 32'(bus.pll_reset), 1);
      tick(1);
      chk("t2_wait3", 32'(bus.pll_reset), 0);
      tick(31);
      chk("t2_no_fault_yet", 32'(bus.fault), 0);
      tick(1);
      chk("t2_fault", 32'(bus.fault), 1);
      chk("t2_fault_pll_reset", 32'(bus.pll_reset), 1);
      chk("t2_fault_retry", 32'(bus.retry_cnt), 2);
      bus.pll_extlock = 1'b1;
      tick(10);
      chk("t2_fault_ignores_lock", 32'(bus.fault), 1);
      bus.relock_req = 1'b1;
      tick(1);
      bus.relock_req = 1'b0;
      chk("t2_fault_cleared", 32'(bus.fault), 0);
      chk("t2_relock_pll_reset", 32'(bus.pll_reset), 1);
      chk("t2_relock_retry", 32'(bus.retry_cnt), 0);
      tick(3);
      chk("t2_relock_pulse_held", 32'(bus.pll_reset), 1);
      tick(1);
      chk("t2_relock_pulse_end", 32'(bus.pll_reset), 0);

      // reset in STABLE with cnt=5
      tick(6);
      reset = 1'b1;
      tick(1);
      chk_reset_values("t6_reset");
      reset = 1'b0;
      tick(3);
      chk("t6_pll_reset_held", 32'(bus.pll_reset), 1);
      tick(1);
      chk("t6_pll_reset_released", 32'(bus.pll_reset), 0);
      tick(15);
      chk("t6_ready", 32'(bus.ready), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
